// File: rtl/obc_dft_bit_sequencer.sv
`default_nettype none
// ============================================================================
//  obc_dft_bit_sequencer
//  Bit-serial LSB-first slice sequencer and accumulator control for the OBC
//  16-point DFT. Optional frame counter: define OBC_SEQ_FRAME_CNT_EN.
//  Revision: 1.0
// ============================================================================
module obc_dft_bit_sequencer #(
    parameter int DATA_W = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [16*DATA_W-1:0] in_data,
    output logic [15:0]          bit_slice,
    output logic                 acc_clr,
    output logic                 acc_en,
    output logic                 acc_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
`ifdef OBC_SEQ_FRAME_CNT_EN
    ,
    output logic [15:0]          frame_cnt
`endif
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   bit_cnt_inc;
    logic [DATA_W-1:0]  sr_q [16];
    logic [DATA_W-1:0]  sr_d [16];
    logic [15:0]        bit_slice_q, bit_slice_d;
    logic               acc_clr_q, acc_clr_d;
    logic               acc_en_q, acc_en_d;
    logic               acc_last_q, acc_last_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;
    logic               in_ready_q, in_ready_d;

    assign bit_cnt_inc = bit_cnt_q + CNT_W'(1);

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        sr_d        = sr_q;
        bit_slice_d = '0;
        acc_clr_d   = 1'b0;
        acc_en_d    = 1'b0;
        acc_last_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        in_ready_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    // Slice 0 is presented straight from in_data so it appears
                    // the cycle after capture; the regs keep the remaining bits.
                    state_d   = S_RUN;
                    bit_cnt_d = '0;
                    for (int n = 0; n < 16; n++) begin
                        bit_slice_d[n] = in_data[n*DATA_W];
                        sr_d[n]        = in_data[n*DATA_W +: DATA_W] >> 1;
                    end
                    acc_clr_d = 1'b1;
                    acc_en_d  = 1'b1;
                    busy_d    = 1'b1;
                end else begin
                    in_ready_d = 1'b1;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (bit_cnt_q == LAST_K) begin
                    state_d     = S_HOLD;
                    bit_cnt_d   = '0;
                    out_valid_d = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt_inc;
                    for (int n = 0; n < 16; n++) begin
                        bit_slice_d[n] = sr_q[n][0];
                        sr_d[n]        = sr_q[n] >> 1;
                    end
                    acc_en_d   = 1'b1;
                    acc_last_d = (bit_cnt_inc == LAST_K);
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d    = S_IDLE;
                    in_ready_d = 1'b1;
                end else begin
                    out_valid_d = 1'b1;
                    busy_d      = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            for (int n = 0; n < 16; n++) begin
                sr_q[n] <= '0;
            end
            bit_slice_q <= '0;
            acc_clr_q   <= 1'b0;
            acc_en_q    <= 1'b0;
            acc_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            sr_q        <= sr_d;
            bit_slice_q <= bit_slice_d;
            acc_clr_q   <= acc_clr_d;
            acc_en_q    <= acc_en_d;
            acc_last_q  <= acc_last_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign bit_slice = bit_slice_q;
    assign acc_clr   = acc_clr_q;
    assign acc_en    = acc_en_q;
    assign acc_last  = acc_last_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

`ifdef OBC_SEQ_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (out_valid_q && out_ready) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

endmodule
`default_nettype wire
